spi_xfer_ctrl: RTL and testbench
================================

// Module: spi_xfer_ctrl
// PURPOSE
//  SPI master sequencer for the bitrev SPI slave and other simple slaves on the same bus.
//  - Accepts one transfer request at a time: tx word, bit count, slave select, bit order.
//  - Generates ss_n, sck and mosi, and assembles the received word from miso.
//  - Pulses done when the transfer ends.
//  - Sits between the CPU-side peripheral bridge and the SPI slave pins.
// PARAMETERS
//  DATA_W  16  max bits per transfer; width of tx/rx words
//  LEN_W   5   width of req_len; must hold DATA_W
//  DIV_W   8   width of the clock divider config
//  NSS     2   number of slave-select lines
// PORTS
//  clock      in   1             system clock; all logic on posedge
//  reset      in   1             asynchronous, active-high
//  req_valid  in   1             transfer request
//  req_ready  out  1             high in IDLE only; accept = req_valid & req_ready
//  req_data   in   DATA_W        tx word
//  req_len    in   LEN_W         bits to transfer, 1..DATA_W; 0 means DATA_W
//  req_sel    in   $clog2(NSS)   index of the ss_n line to assert
//  req_lsb    in   1             0 = MSB first, 1 = LSB first
//  cfg_div    in   DIV_W         half-period H = cfg_div+1 clocks
//  done       out  1             one-cycle pulse at transfer end
//  rx_data    out  DATA_W        received word; updated at done, held until the next done
//  busy       out  1             high from accept until done, inclusive of the done cycle
//  sck        out  1             SPI clock; idles low
//  ss_n       out  NSS           active-low selects; at most one low at a time
//  mosi       out  1             idles high
//  miso       in   1             from the selected slave
// BEHAVIOUR
//  Reset: state IDLE; sck=0; ss_n=all 1; mosi=1; done=0; busy=0; rx_data=0; req_ready=1.
//  At accept, latch req_data, req_len, req_sel, req_lsb and cfg_div.
//   - Later changes to these inputs do not affect the transfer in flight.
//  States, each phase lasting H clocks (counter reloads on every phase change):
//  - IDLE: on accept, go to SETUP.
//    - ss_n[sel]=0; mosi = bit 0 of the transfer.
//  - SETUP: sck=0. At the end, go to HIGH with k=0.
//  - HIGH_k: entered with sck<=1 and mosi<=bit k (registered together). At the end, go to LOW_k.
//  - LOW_k: entered with sck<=0.
//    - The slave samples mosi and updates miso on this falling edge.
//    - On the last clock of LOW_k, sample miso into rx bit k.
//    - Then: k<len-1 -> HIGH_{k+1}; else -> GAP.
//  - GAP: ss_n=all 1, mosi=1, sck=0. At the end, go to IDLE.
//    - On that same clock: done=1, rx_data updated, busy drops next cycle.
//  Bit k mapping:
//   - MSB first: tx bit k = data[len-1-k]; rx bit k -> rx[len-1-k].
//   - LSB first: tx bit k = data[k]; rx bit k -> rx[k].
//   - rx bits at or above len are 0.
//  Latency from accept to done = H*(2+2*len) clocks.
//  - Example: cfg_div=0, len=16 -> 34 clocks.
//  Back-to-back transfers: req_ready returns the cycle after done, so ss_n is high for at least H+1 clocks.
//  req_valid while busy: ignored; req_ready=0. The requester holds req_valid.
//  req_sel >= NSS: the transfer runs with no ss_n asserted; rx_data is undefined; done still pulses.
//  cfg_div at max (all 1s): H=2^DIV_W; the counter must not wrap early.
//  Reset mid-transfer: outputs return to reset values asynchronously.
//   - ss_n high aborts the slave (it reinitialises on its next sck edge).
//   - No done pulse is issued for the aborted transfer.
// STRUCTURE
//  Shared package/include spi_ctrl_defs:
//   - state encoding localparams (IDLE, SETUP, HIGH, LOW, GAP).
//   - SPI idle levels (SCK_IDLE=0, MOSI_IDLE=1).
//  Sub-module spi_half_div:
//   - DIV_W down-counter; load on phase start; tick on last clock of a half-period.
//  Top: FSM, bit index k (LEN_W), tx/rx shift logic, ss decode.
// TESTING (bench instantiates bitrev on ss_n[0]; scoreboard counts clocks)
//  1. Reset held 3 clocks, then released.
//     -> sck=0, ss_n=2'b11, mosi=1, busy=0, req_ready=1, done never pulses.
//  2. cfg_div=0, len=16, MSB first, data=16'hA500, sel=0.
//     -> done exactly 34 clocks after accept; rx_data[7:0]=8'hA5.
//  3. cfg_div=3, same request.
//     -> done after 136 clocks; every sck high/low phase is exactly 4 clocks; rx_data[7:0]=8'hA5.
//  4. LSB first, len=16, data=16'h0001.
//     -> slave echoes 1,0,0,0,0,0,0,0; rx_data[15:8]=8'h01.
//  5. Two back-to-back requests; req_valid held high and data changed during busy.
//     -> second accept 1 clock after first done; first rx unaffected; ss_n high >=H+1 clocks between transfers.
//  6. Reset asserted at LOW_5 of a transfer.
//     -> same clock: ss_n=all 1, sck=0; no done.
//     -> after release, a fresh len=16 A500 transfer still gives rx_data[7:0]=8'hA5.

Source files
------------

// File: rtl/spi_ctrl_defs.sv
// Shared definitions for the SPI transfer controller: state encoding, bus idle levels
// and the mapping from transfer-bit order to word-bit position.
package spi_ctrl_defs;

   typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StGap} state_e;

   localparam logic SCK_IDLE  = 1'b0;
   localparam logic MOSI_IDLE = 1'b1;

   // Word position of transfer bit k in a len-bit transfer.
   function automatic int unsigned bit_index(input int unsigned k, input int unsigned len,
                                             input logic lsb);
      return lsb ? k : (len - 1 - k);
   endfunction

endpackage

// File: rtl/spi_half_div.sv
// Half-period timer: a down-counter reloaded at every phase start; tick marks the last
// clock of the half-period, pre_tick the clock before it.
module spi_half_div #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_val_i,
   output logic             tick_o,
   output logic             pre_tick_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o     = (cnt_q == '0);
   assign pre_tick_o = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master sequencer: runs one latched request through SETUP, len HIGH/LOW bit pairs
// and GAP, driving ss_n/sck/mosi and assembling the received word from miso.
module spi_xfer_ctrl
   import spi_ctrl_defs::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 5,
   parameter int unsigned DIV_W  = 8,
   parameter int unsigned NSS    = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [DATA_W-1:0]        req_data,
   input  logic [LEN_W-1:0]         req_len,
   input  logic [$clog2(NSS)-1:0]   req_sel,
   input  logic                     req_lsb,
   input  logic [DIV_W-1:0]         cfg_div,
   output logic                     done,
   output logic [DATA_W-1:0]        rx_data,
   output logic                     busy,
   output logic                     sck,
   output logic [NSS-1:0]           ss_n,
   output logic                     mosi,
   input  logic                     miso
);

   localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_e            state_q;
   logic [DATA_W-1:0] tx_q, rx_q, rx_data_q;
   logic [LEN_W-1:0]  len_q, k_q;
   logic              lsb_q;
   logic [DIV_W-1:0]  div_q;
   logic              sck_q, mosi_q, done_q;
   logic [NSS-1:0]    ss_n_q;

   logic              accept, tick, pre_tick, div_load;
   logic [DIV_W-1:0]  div_load_val;
   logic [LEN_W-1:0]  req_len_eff, k_next;
   logic [IDX_W-1:0]  cur_pos, next_pos, first_pos;
   logic              last_bit;
   logic [DATA_W-1:0] rx_upd;
   logic [NSS-1:0]    ss_sel;

   always_comb begin
      req_ready    = (state_q == StIdle);
      busy         = (state_q != StIdle);
      accept       = req_valid & req_ready;
      req_len_eff  = (req_len == '0) ? LEN_W'(DATA_W) : req_len;
      first_pos    = IDX_W'(bit_index(0, 32'(req_len_eff), req_lsb));
      k_next       = k_q + 1'b1;
      last_bit     = (k_q == len_q - 1'b1);
      cur_pos      = IDX_W'(bit_index(32'(k_q), 32'(len_q), lsb_q));
      next_pos     = IDX_W'(bit_index(32'(k_next), 32'(len_q), lsb_q));
      rx_upd       = rx_q;
      rx_upd[cur_pos] = miso;
      div_load     = accept | ((state_q != StIdle) & tick);
      div_load_val = (state_q == StIdle) ? cfg_div : div_q;
      // An out-of-range select leaves every line deasserted.
      for (int unsigned i = 0; i < NSS; i++) begin
         ss_sel[i] = (32'(req_sel) != i);
      end
   end

   spi_half_div #(
      .DIV_W (DIV_W)
   ) u_half_div (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (div_load),
      .load_val_i (div_load_val),
      .tick_o     (tick),
      .pre_tick_o (pre_tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         len_q     <= '0;
         k_q       <= '0;
         lsb_q     <= 1'b0;
         div_q     <= '0;
         sck_q     <= SCK_IDLE;
         mosi_q    <= MOSI_IDLE;
         ss_n_q    <= '1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  tx_q    <= req_data;
                  rx_q    <= '0;
                  len_q   <= req_len_eff;
                  lsb_q   <= req_lsb;
                  div_q   <= cfg_div;
                  k_q     <= '0;
                  ss_n_q  <= ss_sel;
                  mosi_q  <= req_data[first_pos];
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               if (tick) begin
                  sck_q   <= 1'b1;
                  mosi_q  <= tx_q[cur_pos];
                  state_q <= StHigh;
               end
            end
            StHigh: begin
               if (tick) begin
                  sck_q   <= 1'b0;
                  state_q <= StLow;
               end
            end
            StLow: begin
               if (tick) begin
                  rx_q <= rx_upd;
                  if (last_bit) begin
                     ss_n_q  <= '1;
                     mosi_q  <= MOSI_IDLE;
                     state_q <= StGap;
                     // A one-clock GAP is its own last clock, so done starts right away.
                     if (div_q == '0) begin
                        done_q    <= 1'b1;
                        rx_data_q <= rx_upd;
                     end
                  end else begin
                     k_q     <= k_next;
                     sck_q   <= 1'b1;
                     mosi_q  <= tx_q[next_pos];
                     state_q <= StHigh;
                  end
               end
            end
            StGap: begin
               if (tick) begin
                  state_q <= StIdle;
               end else if (pre_tick) begin
                  done_q    <= 1'b1;
                  rx_data_q <= rx_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign sck     = sck_q;
   assign ss_n    = ss_n_q;
   assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: echo slave on ss_n[0], cycle-level reference model checked
// every clock, plus directed transfers with literal latency/rx expectations.
module tb_spi_xfer_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [15:0] req_data = '0;
   logic [4:0]  req_len = '0;
   logic [0:0]  req_sel = '0;
   logic        req_lsb = 1'b0;
   logic [7:0]  cfg_div = '0;
   logic        done, busy, sck, mosi;
   logic        miso = 1'b0;
   logic [15:0] rx_data;
   logic [1:0]  ss_n;

   int checks = 0;
   int errors = 0;

   spi_xfer_ctrl #(
      .DATA_W (16),
      .LEN_W  (5),
      .DIV_W  (8),
      .NSS    (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_len   (req_len),
      .req_sel   (req_sel),
      .req_lsb   (req_lsb),
      .cfg_div   (cfg_div),
      .done      (done),
      .rx_data   (rx_data),
      .busy      (busy),
      .sck       (sck),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .miso      (miso)
   );

   always #5 clock = ~clock;

   // Echo slave: on each falling sck it takes mosi, then drives the bit received 8 earlier.
   int   scnt = 0;
   logic rbits [0:31];
   always @(negedge sck or posedge ss_n[0]) begin
      if (ss_n[0]) begin
         scnt = 0;
      end else begin
         if (scnt < 32) rbits[scnt] = mosi;
         miso = (scnt >= 8 && scnt < 40) ? rbits[scnt-8] : 1'b0;
         scnt++;
      end
   end

   function automatic logic txbit(input logic [15:0] d, input int l, input logic lsb,
                                  input int j);
      return lsb ? d[j] : d[l-1-j];
   endfunction

   function automatic logic [15:0] exp_rx(input logic [15:0] d, input int l, input logic lsb);
      logic [15:0] r;
      int pos;
      r = '0;
      for (int k = 0; k < l; k++) begin
         pos = lsb ? k : l - 1 - k;
         r[pos] = (k >= 8) ? txbit(d, l, lsb, k - 8) : 1'b0;
      end
      return r;
   endfunction

   // Reference model: m_n counts clocks since the accepting edge.
   logic        m_act = 1'b0;
   int          m_n = 0, m_h = 1, m_l = 16, m_acc = 0;
   logic [15:0] m_d = '0, m_rx = '0;
   logic        m_lsb = 1'b0, m_sel = 1'b0, m_rxok = 1'b1;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_act  <= 1'b0;
         m_n    <= 0;
         m_rx   <= '0;
         m_rxok <= 1'b1;
      end else if (m_act) begin
         m_n <= m_n + 1;
         if (m_n + 1 == m_h * (2 * m_l + 2) - 1) begin
            m_rx   <= exp_rx(m_d, m_l, m_lsb);
            m_rxok <= (m_sel == 1'b0);
         end
         if (m_n + 1 == m_h * (2 * m_l + 2)) m_act <= 1'b0;
      end else if (req_valid) begin
         m_d   <= req_data;
         m_lsb <= req_lsb;
         m_sel <= req_sel;
         m_h   <= int'(cfg_div) + 1;
         m_l   <= (req_len == 5'd0) ? 16 : int'(req_len);
         m_n   <= 0;
         m_act <= 1'b1;
         m_acc <= m_acc + 1;
      end
   end

   // Packed {done,busy,req_ready,sck,mosi,ss_n,rx_data}.
   function automatic logic [22:0] exp_outs();
      int p, n_tot;
      logic [1:0] ss;
      logic sk, mo;
      if (!m_act) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, m_rx};
      n_tot = m_h * (2 * m_l + 2);
      p = m_n / m_h;
      ss = 2'b11;
      sk = 1'b0;
      mo = 1'b1;
      if (p <= 2 * m_l) begin
         ss[m_sel] = 1'b0;
         sk = (p % 2 == 1);
         mo = txbit(m_d, m_l, m_lsb, (p == 0) ? 0 : (p - 1) / 2);
      end
      return {(m_n == n_tot - 1), 1'b1, 1'b0, sk, mo, ss, m_rx};
   endfunction

   logic [22:0] act_v, exp_v;
   always @(negedge clock) begin
      act_v = {done, busy, req_ready, sck, mosi, ss_n, rx_data};
      exp_v = exp_outs();
      if (!m_rxok) begin
         act_v[15:0] = '0;
         exp_v[15:0] = '0;
      end
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL cycle t=%0t done/busy/ready/sck/mosi/ss_n/rx got %b/%b/%b/%b/%b/%b/%h want %b/%b/%b/%b/%b/%b/%h",
                  $time, act_v[22], act_v[21], act_v[20], act_v[19], act_v[18], act_v[17:16],
                  act_v[15:0], exp_v[22], exp_v[21], exp_v[20], exp_v[19], exp_v[18],
                  exp_v[17:16], exp_v[15:0]);
      end
   end

   // Length of the most recent completed run of clocks with every select high.
   int ss_run = 0, ss_hi_run = 0;
   always @(negedge clock) begin
      if (ss_n == 2'b11) begin
         ss_run++;
      end else begin
         if (ss_run > 0) ss_hi_run = ss_run;
         ss_run = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, a, e);
      end
   endtask

   task automatic issue(input logic [15:0] d, input logic [4:0] l, input logic lsb,
                        input logic sel, input logic [7:0] div);
      req_data  = d;
      req_len   = l;
      req_lsb   = lsb;
      req_sel   = sel;
      cfg_div   = div;
      req_valid = 1'b1;
   endtask

   task automatic wait_accept(input string name, output int n);
      int prev;
      prev = m_acc;
      n = -1;
      for (int i = 1; i <= 600; i++) begin
         @(posedge clock);
         #1;
         if (m_acc != prev) begin
            n = i;
            break;
         end
      end
      if (n < 0) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_done(output int c);
      c = -1;
      for (int i = 1; i <= 3000; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            c = i;
            break;
         end
      end
   endtask

   task automatic xfer(input string name, input logic [15:0] d, input logic [4:0] l,
                       input logic lsb, input logic sel, input logic [7:0] div,
                       input int exp_lat, input bit chk_rx, input logic [15:0] exp_r);
      int n, c;
      issue(d, l, lsb, sel, div);
      wait_accept(name, n);
      req_valid = 1'b0;
      wait_done(c);
      chk({name, "_latency"}, c, exp_lat);
      if (chk_rx) chk({name, "_rx"}, rx_data, exp_r);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, c;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_sck", sck, 0);
      chk("rst_ss_n", ss_n, 2'b11);
      chk("rst_mosi", mosi, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_rx", rx_data, 0);

      xfer("msb_div0", 16'hA500, 5'd16, 1'b0, 1'b0, 8'd0, 34, 1'b1, 16'h00A5);
      xfer("msb_div3", 16'hA500, 5'd16, 1'b0, 1'b0, 8'd3, 136, 1'b1, 16'h00A5);
      xfer("lsb_0001", 16'h0001, 5'd16, 1'b1, 1'b0, 8'd0, 34, 1'b1, 16'h0100);
      xfer("sel1_len4", 16'h000F, 5'd4, 1'b0, 1'b1, 8'd0, 10, 1'b0, 16'h0000);
      xfer("div_max", 16'h0001, 5'd1, 1'b0, 1'b0, 8'hFF, 1024, 1'b1, 16'h0000);

      // Back-to-back with req_valid held and data changed mid-transfer.
      issue(16'hA500, 5'd16, 1'b0, 1'b0, 8'd1);
      wait_accept("b2b_a", n);
      req_data = 16'h5A00;
      wait_done(c);
      chk("b2b_a_latency", c, 68);
      chk("b2b_a_rx", rx_data, 16'h00A5);
      wait_accept("b2b_b", n);
      req_valid = 1'b0;
      chk("b2b_accept_gap", n, 2);
      wait_done(c);
      chk("b2b_b_latency", c, 68);
      chk("b2b_b_rx", rx_data, 16'h005A);
      chk("b2b_ss_high_run", ss_hi_run, 3);

      // Reset during LOW_5 (13th clock after accept with H=1).
      issue(16'hA500, 5'd16, 1'b0, 1'b0, 8'd0);
      wait_accept("abort", n);
      req_valid = 1'b0;
      repeat (13) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("abort_ss_n", ss_n, 2'b11);
      chk("abort_sck", sck, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      xfer("after_abort", 16'hA500, 5'd0, 1'b0, 1'b0, 8'd0, 34, 1'b1, 16'h00A5);

      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
